// File: rtl/map_probe_arbiter_if.sv
// Mover-side query bus and ROM read port of the map probe arbiter.
// The slave modport is the arbiter; the master modport is the movers plus the ROM.
interface map_probe_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [4*N-1:0] dir_flat;
  logic [9*N-1:0] px_flat;
  logic [9*N-1:0] py_flat;
  logic [N-1:0]   ack;
  logic [N-1:0]   collide;
  logic           busy;
  logic [8:0]     rom_x;
  logic [8:0]     rom_y;
  logic [2:0]     rom_pixel;

  modport master (
    output req, dir_flat, px_flat, py_flat, rom_pixel,
    input  ack, collide, busy, rom_x, rom_y
  );

  modport slave (
    input  req, dir_flat, px_flat, py_flat, rom_pixel,
    output ack, collide, busy, rom_x, rom_y
  );
endinterface

// File: rtl/map_probe_arbiter.sv
// Round-robin sharing of the single map ROM read port among N movers; each query
// returns whether the tile STEP pixels ahead of the mover is a wall or off the map.
module map_probe_arbiter #(
  parameter int N         = 4,
  parameter int STEP      = 13,
  parameter int ROM_LAT   = 0,
  parameter int X_MAX     = 447,
  parameter int Y_MAX     = 495,
  parameter int WALL_CODE = 0
) (
  input logic                clk,
  input logic                rst,
  map_probe_arbiter_if.slave bus
);
  localparam int         IW     = (N > 1) ? $clog2(N) : 1;
  localparam int         CW     = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [9:0] STEP_W = 10'(STEP);
  localparam logic [9:0] XMAX_W = 10'(X_MAX);
  localparam logic [9:0] YMAX_W = 10'(Y_MAX);
  localparam logic [2:0] WALL_W = 3'(WALL_CODE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_gnt;
  logic [CW-1:0] r_cnt;
  logic          r_oob;
  logic          r_busy;
  logic [N-1:0]  r_ack;
  logic [N-1:0]  r_collide;
  logic [8:0]    r_rom_x;
  logic [8:0]    r_rom_y;

  logic [IW-1:0] w_gnt;
  logic [3:0]    w_dir;
  logic [8:0]    w_px;
  logic [8:0]    w_py;
  logic [18:0]   w_probe;
  logic          w_hit;

  // First requester at or after last+1, wrapping; smallest distance wins.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] rq, input logic [IW-1:0] last);
    logic [IW-1:0] pick;
    int            c;
    pick = last;
    for (int k = N; k >= 1; k--) begin
      c = (int'(last) + k) % N;
      if (rq[c]) pick = IW'(c);
    end
    return pick;
  endfunction

  // Returns {oob, probe_y[8:0], probe_x[8:0]}; 10-bit math exposes overflow past 511.
  function automatic logic [18:0] probe_calc(input logic [3:0] d, input logic [8:0] x,
                                             input logic [8:0] y);
    logic [9:0] qx;
    logic [9:0] qy;
    logic       brw;
    qx  = {1'b0, x};
    qy  = {1'b0, y};
    brw = 1'b0;
    case (d)
      4'b1000: begin brw = (qx < STEP_W); qx = qx - STEP_W; end
      4'b0100: begin brw = (qy < STEP_W); qy = qy - STEP_W; end
      4'b0010: qx = qx + STEP_W;
      4'b0001: qy = qy + STEP_W;
      default: ;
    endcase
    return {brw | (qx > XMAX_W) | (qy > YMAX_W), qy[8:0], qx[8:0]};
  endfunction

  assign w_gnt   = rr_pick(bus.req, r_last);
  assign w_dir   = bus.dir_flat[int'(w_gnt)*4 +: 4];
  assign w_px    = bus.px_flat[int'(w_gnt)*9 +: 9];
  assign w_py    = bus.py_flat[int'(w_gnt)*9 +: 9];
  assign w_probe = probe_calc(w_dir, w_px, w_py);
  assign w_hit   = r_oob | (bus.rom_pixel == WALL_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ack     <= '0;
      r_collide <= '0;
      r_busy    <= 1'b0;
      r_rom_x   <= '0;
      r_rom_y   <= '0;
      r_last    <= IW'(N - 1);
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_gnt   <= w_gnt;
            r_rom_x <= w_probe[8:0];
            r_rom_y <= w_probe[17:9];
            r_oob   <= w_probe[18];
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ROM_LAT == 0) begin
            r_collide[r_gnt] <= w_hit;
            r_ack[r_gnt]     <= 1'b1;
            r_state          <= DONE;
          end else begin
            r_cnt   <= CW'(ROM_LAT - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_collide[r_gnt] <= w_hit;
            r_ack[r_gnt]     <= 1'b1;
            r_state          <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_last  <= r_gnt;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack     = r_ack;
  assign bus.collide = r_collide;
  assign bus.busy    = r_busy;
  assign bus.rom_x   = r_rom_x;
  assign bus.rom_y   = r_rom_y;
endmodule

// File: tb/tb_map_probe_arbiter.sv
// Bench for map_probe_arbiter: three instances (ROM latency 0, 2, 3) driven by directed
// steps, with expected acks queued per instance and checked when they appear.
module tb_map_probe_arbiter;
  typedef struct {
    int   idx;
    logic col;
    int   cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  req [3];
  logic [15:0] dir [3];
  logic [35:0] px  [3];
  logic [35:0] py  [3];
  logic [8:0]  wx  [3];
  logic [8:0]  wy  [3];

  wire [3:0] ack_w     [3];
  wire [3:0] collide_w [3];
  wire       busy_w    [3];
  wire [8:0] rx_w      [3];
  wire [8:0] ry_w      [3];

  logic [2:0] p1a = 3'd3, p1b = 3'd3;
  logic [2:0] p2a = 3'd3, p2b = 3'd3, p2c = 3'd3;

  exp_t sb [3][$];

  map_probe_arbiter_if #(.N(4)) if0 ();
  map_probe_arbiter_if #(.N(4)) if1 ();
  map_probe_arbiter_if #(.N(4)) if2 ();

  map_probe_arbiter #(.N(4), .ROM_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  map_probe_arbiter #(.N(4), .ROM_LAT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  map_probe_arbiter #(.N(4), .ROM_LAT(3)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.req = req[0];  assign if0.dir_flat = dir[0];
  assign if0.px_flat = px[0]; assign if0.py_flat = py[0];
  assign if1.req = req[1];  assign if1.dir_flat = dir[1];
  assign if1.px_flat = px[1]; assign if1.py_flat = py[1];
  assign if2.req = req[2];  assign if2.dir_flat = dir[2];
  assign if2.px_flat = px[2]; assign if2.py_flat = py[2];

  assign ack_w[0] = if0.ack; assign collide_w[0] = if0.collide; assign busy_w[0] = if0.busy;
  assign ack_w[1] = if1.ack; assign collide_w[1] = if1.collide; assign busy_w[1] = if1.busy;
  assign ack_w[2] = if2.ack; assign collide_w[2] = if2.collide; assign busy_w[2] = if2.busy;
  assign rx_w[0] = if0.rom_x; assign ry_w[0] = if0.rom_y;
  assign rx_w[1] = if1.rom_x; assign ry_w[1] = if1.rom_y;
  assign rx_w[2] = if2.rom_x; assign ry_w[2] = if2.rom_y;

  // ROM model: a single wall pixel per instance, delayed by that instance's latency.
  assign if0.rom_pixel = (if0.rom_x == wx[0] && if0.rom_y == wy[0]) ? 3'd0 : 3'd3;
  assign if1.rom_pixel = p1b;
  assign if2.rom_pixel = p2c;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1a <= (if1.rom_x == wx[1] && if1.rom_y == wy[1]) ? 3'd0 : 3'd3;
    p1b <= p1a;
    p2a <= (if2.rom_x == wx[2] && if2.rom_y == wy[2]) ? 3'd0 : 3'd3;
    p2b <= p2a;
    p2c <= p2b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  // Scoreboard consumer: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ack_w[d] !== 4'b0) begin
        if (sb[d].size() == 0) begin
          check("ack_unexpected", 32'(ack_w[d]), 32'd0);
        end else begin
          e = sb[d].pop_front();
          check("ack_vec", 32'(ack_w[d]), 32'(4'b0001 << e.idx));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          check("collide_bit", 32'(collide_w[d][e.idx]), 32'(e.col));
        end
      end
    end
  end

  task automatic wait_ack(input int d);
    logic [3:0] seen;
    bit         got;
    got  = 1'b0;
    seen = 4'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack_w[d] !== 4'b0) begin
        got  = 1'b1;
        seen = ack_w[d];
      end
    end
    check("ack_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    req[d] = req[d] & ~seen;
  endtask

  // mode 1: move px in ISSUE; mode 2: drop req in the cycle after ISSUE.
  task automatic query(input int d, input int idx, input logic [3:0] dr, input int x,
                       input int y, input int erx, input int ery, input logic ecol,
                       input int mode);
    exp_t e;
    @(posedge clk); #1;
    dir[d][4*idx +: 4] = dr;
    px[d][9*idx +: 9]  = x[8:0];
    py[d][9*idx +: 9]  = y[8:0];
    req[d][idx]        = 1'b1;
    e.idx = idx; e.col = ecol; e.cyc = cyc + 2 + lat(d);
    sb[d].push_back(e);
    @(posedge clk); #1;
    if (mode == 1) px[d][9*idx +: 9] = 9'd300;
    check("rom_x", 32'(rx_w[d]), 32'(erx));
    check("rom_y", 32'(ry_w[d]), 32'(ery));
    check("busy", 32'(busy_w[d]), 32'd1);
    if (mode == 2) begin
      @(posedge clk); #1;
      req[d][idx] = 1'b0;
    end
    wait_ack(d);
  endtask

  // All four request at once; requester 2 sits on the wall pixel.
  task automatic rr(input int d, input int o0, input int o1, input int o2, input int o3);
    int   ord [4];
    int   base;
    exp_t e;
    ord = '{o0, o1, o2, o3};
    @(posedge clk); #1;
    req[d] = 4'b1111;
    base   = cyc;
    for (int k = 0; k < 4; k++) begin
      e.idx = ord[k]; e.col = (ord[k] == 2); e.cyc = base + 2 + lat(d) + k * (3 + lat(d));
      sb[d].push_back(e);
    end
    for (int k = 0; k < 4; k++) wait_ack(d);
  endtask

  initial begin
    exp_t e;
    int   base;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = '0; dir[d] = '0; px[d] = '0; py[d] = '0;
    end
    wx[0] = 9'd113; wy[0] = 9'd50;
    wx[1] = 9'd50;  wy[1] = 9'd37;
    wx[2] = 9'd60;  wy[2] = 9'd60;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check("rst_ack", 32'(ack_w[d]), 32'd0);
      check("rst_busy", 32'(busy_w[d]), 32'd0);
      check("rst_collide", 32'(collide_w[d]), 32'd0);
      check("rst_rom_x", 32'(rx_w[d]), 32'd0);
      check("rst_rom_y", 32'(ry_w[d]), 32'd0);
    end

    // Round-robin on the zero-latency instance
    for (int i = 0; i < 4; i++) begin
      dir[0][4*i +: 4] = 4'b0000;
      px[0][9*i +: 9]  = (i == 2) ? 9'd113 : 9'(10 + i);
      py[0][9*i +: 9]  = (i == 2) ? 9'd50 : 9'd20;
    end
    rr(0, 0, 1, 2, 3);
    check("rr_collide_vec", 32'(collide_w[0]), 32'h4);
    query(0, 1, 4'b0000, 11, 20, 11, 20, 1'b0, 0);
    rr(0, 2, 3, 0, 1);

    // Probe arithmetic and map boundaries
    query(0, 0, 4'b0010, 100, 50, 113, 50, 1'b1, 1);
    query(0, 0, 4'b1000, 100, 50, 87, 50, 1'b0, 0);
    query(0, 0, 4'b1000, 5, 50, 504, 50, 1'b1, 0);
    query(0, 0, 4'b0000, 30, 40, 30, 40, 1'b0, 0);
    query(0, 0, 4'b0010, 440, 60, 453, 60, 1'b1, 0);
    query(0, 0, 4'b1010, 30, 40, 30, 40, 1'b0, 0);
    query(0, 3, 4'b0100, 200, 5, 200, 504, 1'b1, 0);
    query(0, 1, 4'b0001, 100, 490, 100, 503, 1'b1, 0);

    // Latency-2 instance
    query(1, 0, 4'b0100, 50, 50, 50, 37, 1'b1, 0);
    query(1, 1, 4'b0001, 200, 200, 200, 213, 1'b0, 0);
    check("other_collide_kept", 32'(collide_w[1]), 32'h1);
    query(1, 2, 4'b0010, 100, 100, 113, 100, 1'b0, 2);

    // Latency-3 instance: reset while in WAIT
    query(2, 0, 4'b0000, 60, 60, 60, 60, 1'b1, 0);
    @(posedge clk); #1;
    dir[2][7:4] = 4'b0000; px[2][17:9] = 9'd70; py[2][17:9] = 9'd70;
    req[2] = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_wait", 32'(busy_w[2]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req[2] = 4'b0000;
    check("rst_mid_busy", 32'(busy_w[2]), 32'd0);
    check("rst_mid_collide", 32'(collide_w[2]), 32'd0);
    check("rst_mid_ack", 32'(ack_w[2]), 32'd0);
    check("rst_mid_rom_x", 32'(rx_w[2]), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    req[2] = 4'b0011;
    base   = cyc;
    e.idx = 0; e.col = 1'b1; e.cyc = base + 5;  sb[2].push_back(e);
    e.idx = 1; e.col = 1'b0; e.cyc = base + 11; sb[2].push_back(e);
    wait_ack(2);
    wait_ack(2);

    repeat (4) @(posedge clk);
    for (int d = 0; d < 3; d++) check("sb_drained", 32'(sb[d].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/map_probe_arbiter.md
Name: map_probe_arbiter

Overview:
- Shares the single map ROM read port among N movers: Pac-Man plus the ghosts.
- Each mover asks whether the tile one STEP ahead in its direction is a wall.
- Arbitrates requests round-robin, computes the probe coordinate, and drives the ROM address.
- Waits the ROM latency, then returns a per-requester collide flag with a one-cycle ack.

Parameters:
N, 4, number of requesters (index 0 = Pac-Man, 1..N-1 = ghosts)
STEP, 13, probe offset in pixels along the direction of travel
ROM_LAT, 0, cycles from rom_x/rom_y valid to rom_pixel valid (0 = combinational ROM)
X_MAX, 447, largest legal map x coordinate
Y_MAX, 495, largest legal map y coordinate
WALL_CODE, 0, rom_pixel value meaning wall

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  N  per-requester query request, level
dir_flat  in  4N  per-requester direction, one-hot: 1000 left, 0100 up, 0010 right, 0001 down; slice i = [4i+3:4i]
px_flat  in  9N  per-requester x position; slice i = [9i+8:9i]
py_flat  in  9N  per-requester y position; slice i = [9i+8:9i]
ack  out  N  one-cycle pulse, result for requester i valid
collide  out  N  per-requester result, held until that requester's next ack
busy  out  1  high in any state other than IDLE
rom_x  out  9  registered ROM x address
rom_y  out  9  registered ROM y address
rom_pixel  in  3  ROM read data

Behaviour:
- Reset values:
  - state=IDLE, ack=0, collide=0, busy=0, rom_x=0, rom_y=0.
  - Round-robin pointer last=N-1, so requester 0 has first priority.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req!=0, grant g = first set bit searching upward from (last+1) mod N, wrapping.
  - Latch dir/px/py of g; compute probe; next state ISSUE.
  - Else stay in IDLE.
- Probe arithmetic:
  - Computed in 10 bits from the latched values.
  - left: x-STEP, y. up: x, y-STEP. right: x+STEP, y. down: x, y+STEP.
  - A direction that is not one-hot (0000, multi-bit) probes x, y unchanged.
  - oob=1 if a subtraction borrows, or if probe x>X_MAX or probe y>Y_MAX.
  - rom_x/rom_y = low 9 bits of the probe, registered at IDLE->ISSUE.
  - rom_x/rom_y hold their value through WAIT and DONE.
- ISSUE: 1 cycle. If ROM_LAT=0, capture rom_pixel at the end of this cycle and go to DONE; else go to WAIT.
- WAIT:
  - Exactly ROM_LAT cycles, counted by a down-counter.
  - Capture rom_pixel at the end of the last WAIT cycle, then go to DONE.
- Result: collide[g] <= oob | (rom_pixel==WALL_CODE). Other collide bits are unchanged.
- DONE:
  - ack[g]=1 for exactly this cycle; last <= g; next state IDLE.
  - Only one ack bit is ever high at a time.
- Latency: req seen in IDLE at cycle 0 -> ack in cycle 2+ROM_LAT. Throughput is one query per 3+ROM_LAT cycles.
- Requester rules:
  - Inputs are sampled only on the grant cycle; later changes do not affect the in-flight query.
  - Requester drops req on the edge after seeing ack. If req is still high in IDLE, it is treated as a new request and competes normally.
  - A req dropped after grant but before ack: the query still completes and ack still pulses.
- Simultaneous requests: resolved only by the rotating priority. No requester waits more than N-1 other grants.
- rst mid-operation (any state): immediate return to reset values next cycle; the in-flight query is discarded with no ack.

Test Plan:
- Single query: reset; req=0001, dir0=0010, px0=100, py0=50; ROM returns 0 at (113,50) -> rom_x=113, rom_y=50 in cycle 1; ack=0001 in cycle 2; collide[0]=1.
- Free path with ROM_LAT=2: req1 dir=0001 at (200,200); ROM returns 3 -> rom_y=213; ack[1] in cycle 4; collide[1]=0; other collide bits unchanged.
- Round-robin: req=1111 held, each requester dropping its own req after its ack -> ack order 0,1,2,3. Restart with req=1111 while last=1 -> order 2,3,0,1.
- Boundary:
  - dir=1000 at x=5 -> oob, collide=1 regardless of rom_pixel.
  - dir=0010 at x=440 -> probe 453>447, collide=1.
  - dir=0000 at (30,40) -> rom_x=30, rom_y=40.
- Input change after grant: px0 changes 100->300 in ISSUE -> rom_x stays 113. Req dropped in WAIT -> ack still pulses.
- Reset in WAIT (ROM_LAT=3): assert rst for 1 cycle -> no ack, busy=0 and state IDLE next cycle, collide=0; the next request is granted to requester 0 first.
